// File: rtl/debug_bridge_pkg.sv
// Shared constants for the UART-to-memory debug bridge: command/response bytes,
// FSM state encodings and a small elaboration-time helper.
package debug_bridge_pkg;

    localparam logic [7:0] CMD_PING  = 8'h50;
    localparam logic [7:0] CMD_HALT  = 8'h48;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h41;
    localparam logic [7:0] RSP_NAK   = 8'h4E;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_GET_ADDR  = 4'd1;
    localparam state_t ST_GET_LEN   = 4'd2;
    localparam state_t ST_GET_DATA  = 4'd3;
    localparam state_t ST_MEM_WR    = 4'd4;
    localparam state_t ST_MEM_RD    = 4'd5;
    localparam state_t ST_SEND_DATA = 4'd6;
    localparam state_t ST_SEND_ACK  = 4'd7;
    localparam state_t ST_SEND_NAK  = 4'd8;

    function automatic int max_int(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debug_bridge_if.sv
// UART byte stream and req/ack memory bus seen by the debug bridge.
// master = bridge side, slave = UART transceiver / memory side.
interface debug_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic [7:0]        tx_byte;
    logic              tx_start;
    logic              tx_busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  rx_byte, rx_valid, tx_busy, mem_rdata, mem_ack,
        output tx_byte, tx_start, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_byte, rx_valid, tx_busy, mem_rdata, mem_ack,
        input  tx_byte, tx_start, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/debug_bridge.sv
// UART-to-memory debug bridge: ping, CPU halt/go, burst read/write with address
// auto-increment over a req/ack memory bus, and an inactivity timeout that answers NAK.
module debug_bridge
    import debug_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic           clk,
    input  logic           rst,
    debug_bridge_if.master bus,
    output logic           cpu_reset_req,
    output state_t         dbg_state
);

    localparam int ABYTES = ADDR_W / 8;
    localparam int DBYTES = DATA_W / 8;
    localparam int BCW    = $clog2(max_int(ADDR_W, DATA_W) / 8) + 1;
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DBYTES);
    localparam logic [7:0]        MAX_LEN   = 8'(MAX_BURST);
    localparam logic [BCW-1:0]    ALAST     = BCW'(ABYTES - 1);
    localparam logic [BCW-1:0]    DLAST     = BCW'(DBYTES - 1);
    localparam logic [TW-1:0]     TLAST     = TW'(TIMEOUT_CYC - 1);

    state_t            state, state_nxt;
    logic [BCW-1:0]    byte_cnt;
    logic [7:0]        word_cnt;
    logic [TW-1:0]     tcnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we, req;
    logic              tx_start, tx_hold;
    logic [7:0]        tx_byte;

    logic counting, tx_ready, ack, len_bad, timeout;

    assign counting = state inside {ST_GET_ADDR, ST_GET_LEN, ST_GET_DATA, ST_MEM_WR, ST_MEM_RD};
    // tx_hold spans the start pulse and the busy period, so a byte goes out only
    // after busy has been seen low once and then stays low for another cycle.
    assign tx_ready = !tx_hold && !bus.tx_busy;
    assign ack      = req && bus.mem_ack;
    assign len_bad  = (bus.rx_byte == 8'd0) || (bus.rx_byte > MAX_LEN);

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_byte)
                        CMD_PING, CMD_HALT, CMD_GO: state_nxt = ST_SEND_ACK;
                        CMD_WRITE, CMD_READ:        state_nxt = ST_GET_ADDR;
                        default:                    state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_GET_ADDR:  if (bus.rx_valid && byte_cnt == ALAST) state_nxt = ST_GET_LEN;
            ST_GET_LEN: begin
                if (bus.rx_valid)
                    state_nxt = len_bad ? ST_SEND_NAK : (we ? ST_GET_DATA : ST_MEM_RD);
            end
            ST_GET_DATA:  if (bus.rx_valid && byte_cnt == DLAST) state_nxt = ST_MEM_WR;
            ST_MEM_WR:    if (ack) state_nxt = (word_cnt > 8'd1) ? ST_GET_DATA : ST_SEND_ACK;
            ST_MEM_RD:    if (ack) state_nxt = ST_SEND_DATA;
            ST_SEND_DATA: begin
                if (tx_ready && byte_cnt == DLAST)
                    state_nxt = (word_cnt != 8'd0) ? ST_MEM_RD : ST_IDLE;
            end
            ST_SEND_ACK:  if (tx_ready) state_nxt = ST_IDLE;
            ST_SEND_NAK:  if (tx_ready) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        // Any byte or completion in the expiring cycle wins over the timeout.
        if (counting && state_nxt == state && !bus.rx_valid && tcnt == TLAST) begin
            timeout   = 1'b1;
            state_nxt = ST_SEND_NAK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cpu_reset_req <= 1'b1;
            byte_cnt      <= '0;
            word_cnt      <= '0;
            tcnt          <= '0;
            addr          <= '0;
            data          <= '0;
            we            <= 1'b0;
            req           <= 1'b0;
            tx_start      <= 1'b0;
            tx_hold       <= 1'b0;
            tx_byte       <= '0;
        end else begin
            state    <= state_nxt;
            tx_start <= 1'b0;
            if (tx_hold && !tx_start && !bus.tx_busy)
                tx_hold <= 1'b0;
            if (bus.rx_valid || state_nxt != state)
                tcnt <= '0;
            else if (counting)
                tcnt <= tcnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        case (bus.rx_byte)
                            CMD_HALT:  cpu_reset_req <= 1'b1;
                            CMD_GO:    cpu_reset_req <= 1'b0;
                            CMD_WRITE: we <= 1'b1;
                            CMD_READ:  we <= 1'b0;
                            default:   ;
                        endcase
                    end
                end
                ST_GET_ADDR: begin
                    if (bus.rx_valid) begin
                        addr     <= (addr << 8) | ADDR_W'(bus.rx_byte);
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                ST_GET_LEN: begin
                    if (bus.rx_valid && !len_bad)
                        word_cnt <= bus.rx_byte;
                end
                ST_GET_DATA: begin
                    if (bus.rx_valid) begin
                        data     <= (data << 8) | DATA_W'(bus.rx_byte);
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                ST_MEM_WR, ST_MEM_RD: begin
                    if (timeout) begin
                        req <= 1'b0;
                    end else if (ack) begin
                        req      <= 1'b0;
                        addr     <= addr + ADDR_STEP;
                        word_cnt <= word_cnt - 8'd1;
                        if (state == ST_MEM_RD)
                            data <= bus.mem_rdata;
                    end else if (!req) begin
                        req <= 1'b1;
                    end
                end
                ST_SEND_DATA: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        tx_hold  <= 1'b1;
                        tx_byte  <= data[DATA_W-1 -: 8];
                        data     <= data << 8;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                ST_SEND_ACK, ST_SEND_NAK: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        tx_hold  <= 1'b1;
                        tx_byte  <= (state == ST_SEND_ACK) ? RSP_ACK : RSP_NAK;
                    end
                end
                default: ;
            endcase

            // Every state change starts the next field from its first byte.
            if (state_nxt != state)
                byte_cnt <= '0;
        end
    end

    assign bus.tx_byte   = tx_byte;
    assign bus.tx_start  = tx_start;
    assign bus.mem_req   = req;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = data;
    assign dbg_state     = state;

endmodule
